pma_decoder: RTL and testbench
==============================

Name: pma_decoder

Overview:
- Registered, table-driven physical-memory-attribute decoder for the crossbar.
- Maps each request address to a target chip select and chip-relative offset, and checks read/write/execute permission.
- The region table has NUM_REGIONS entries, is reset from parameters and is runtime-reprogrammable until locked.
- Sits between the master request port and the crossbar routing stage, with a valid/ready handshake on both sides.

Parameters:
- NUM_REGIONS, 8: number of region table entries; entry index is also the chip select value.
- ADDR_WIDTH, 64: request address and offset width.
- SEL_WIDTH, 6: chip-select width; 2**SEL_WIDTH must be >= NUM_REGIONS.
- BASE_INIT, packed NUM_REGIONS*ADDR_WIDTH: reset base per entry (entry i at bits i*ADDR_WIDTH).
- SIZE_INIT, packed NUM_REGIONS*ADDR_WIDTH: reset size per entry; 0 = entry disabled.
- ATTR_INIT, packed NUM_REGIONS*3: reset attributes per entry; bit0 R, bit1 W, bit2 X.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&&ready
- req_addr  in  ADDR_WIDTH  physical address
- req_op  in  2  00 read, 01 write, 10 fetch, 11 reserved (treated as permission fault)
- rsp_valid  out  1  decode result valid
- rsp_ready  in  1  downstream accepts result
- rsp_sel  out  SEL_WIDTH  matched entry index, 0 on error
- rsp_addr  out  ADDR_WIDTH  req_addr minus base; raw req_addr on error
- rsp_err  out  2  00 ok, 01 no match, 10 permission fault
- cfg_we  in  1  table write strobe
- cfg_idx  in  SEL_WIDTH  entry to write; indices >= NUM_REGIONS are ignored
- cfg_field  in  2  00 base, 01 size, 10 attr (low 3 bits), 11 lock
- cfg_wdata  in  ADDR_WIDTH  write data
- cfg_locked  out  1  table lock status

Behaviour:
- Reset (async, rst=1):
  - rsp_valid=0, rsp_sel=0, rsp_addr=0, rsp_err=0, cfg_locked=0.
  - Table loaded from BASE_INIT, SIZE_INIT and ATTR_INIT.
  - Reset asserted mid-transaction drops any held result; no response is produced for it.
- Output register:
  - Single output register; req_ready = !rsp_valid || rsp_ready (combinational).
  - Latency is 1 cycle: a request accepted in cycle N is presented in cycle N+1.
  - Full throughput when rsp_ready is held at 1.
  - rsp_* stay stable while rsp_valid && !rsp_ready.
- Match rule, entry i:
  - size!=0 && req_addr>=base && (req_addr-base)<size.
  - Use the unsigned subtract-and-compare form; base+size is never computed, so a region ending at 2**ADDR_WIDTH does not overflow.
- Priority: the lowest matching index wins, so overlapping entries are legal.
- Permission check against the winning entry:
  - read needs R, write needs W, fetch needs X; op 11 always faults.
- Result selection:
  - No match: err=01, sel=0, addr=req_addr.
  - Match with permission fault: err=10, sel=0, addr=req_addr.
  - Otherwise: err=00, sel=i, addr=req_addr-base[i].
- Config writes:
  - Take effect at the clock edge.
  - A request accepted in the same cycle decodes against the pre-write table.
  - A held (stalled) result is never re-decoded.
- Lock:
  - A write with cfg_field=11 and cfg_wdata[0]=1 sets cfg_locked.
  - The lock is sticky until rst; while it is set, all cfg writes are ignored, including unlock attempts.
- Bad config index: cfg_idx >= NUM_REGIONS has no effect, for both data writes and lock writes.
- Default table for NUM_REGIONS=5:
  - 0: zero page, base 0x0, size 0x1000, attr none.
  - 1: ROM, base 0x1000, size 0xFFFF000, attr RX.
  - 2: UART, base 0x10000000, size 0x100, attr RW.
  - 3: MMIO-BLK, base 0x10001000, size 0x1000, attr RW.
  - 4: RAM, base 0x80000000, size 0x80000000, attr RWX.
  - Extra entries: size 0.

Test Plan:
- Default table, read 0x80001234 -> next cycle rsp_valid=1, sel=4, addr=0x1234, err=00; read 0x10000010 -> sel=2, addr=0x10.
- Fetch 0x10000000 (UART, no X) -> err=10, sel=0, addr=0x10000000; read 0x20000000 -> err=01.
- Boundaries: read 0x100000FF -> sel=2, addr=0xFF; read 0x10000100 -> err=01; read 0xFFFFFFFF -> sel=4, addr=0x7FFFFFFF.
- Back-pressure: hold rsp_ready=0 with two requests pending -> req_ready=0, first result held stable; release rsp_ready -> results delivered in order, one per cycle, no loss or duplication.
- Reprogram: write entry 5 base 0x40000000, size 0x1000, attr RW, in the same cycle a read of 0x40000010 is accepted -> err=01; repeat the read -> sel=5, addr=0x10. Overlap test: set entry 2 to cover 0x80000000 -> sel=2 wins over 4.
- Lock: write lock; then write entry 1 size=0 -> ignored, ROM reads still hit sel=1. Assert rst mid-stall -> rsp_valid=0 and cfg_locked=0 immediately.

Source files
------------

// File: rtl/pma_decoder_if.sv
// Request/response and table-configuration bundle between the requesting master and pma_decoder.
interface pma_decoder_if #(
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned SEL_WIDTH  = 6
);
   logic                  req_valid;
   logic                  req_ready;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [1:0]            req_op;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [SEL_WIDTH-1:0]  rsp_sel;
   logic [ADDR_WIDTH-1:0] rsp_addr;
   logic [1:0]            rsp_err;
   logic                  cfg_we;
   logic [SEL_WIDTH-1:0]  cfg_idx;
   logic [1:0]            cfg_field;
   logic [ADDR_WIDTH-1:0] cfg_wdata;
   logic                  cfg_locked;

   modport master (
      output req_valid, req_addr, req_op, rsp_ready,
             cfg_we, cfg_idx, cfg_field, cfg_wdata,
      input  req_ready, rsp_valid, rsp_sel, rsp_addr, rsp_err, cfg_locked
   );

   modport slave (
      input  req_valid, req_addr, req_op, rsp_ready,
             cfg_we, cfg_idx, cfg_field, cfg_wdata,
      output req_ready, rsp_valid, rsp_sel, rsp_addr, rsp_err, cfg_locked
   );
endinterface

// File: rtl/pma_decoder.sv
// Registered physical-memory-attribute decoder: address -> chip select + offset with R/W/X check.
// Region table is reset from parameters and runtime-writable until locked.
module pma_decoder #(
   parameter int unsigned NUM_REGIONS = 8,
   parameter int unsigned ADDR_WIDTH  = 64,
   parameter int unsigned SEL_WIDTH   = 6,
   parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] BASE_INIT = (NUM_REGIONS*ADDR_WIDTH)'({
      64'h0, 64'h0, 64'h0, 64'h8000_0000,
      64'h1000_1000, 64'h1000_0000, 64'h0000_1000, 64'h0}),
   parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] SIZE_INIT = (NUM_REGIONS*ADDR_WIDTH)'({
      64'h0, 64'h0, 64'h0, 64'h8000_0000,
      64'h0000_1000, 64'h0000_0100, 64'h0FFF_F000, 64'h1000}),
   parameter logic [NUM_REGIONS*3-1:0] ATTR_INIT = (NUM_REGIONS*3)'({
      3'b000, 3'b000, 3'b000, 3'b111, 3'b011, 3'b011, 3'b101, 3'b000})
) (
   input  logic           clk,
   input  logic           rst,
   pma_decoder_if.slave   bus
);
   localparam int unsigned    AW          = ADDR_WIDTH;
   localparam logic [SEL_WIDTH:0] NUM_IDX = (SEL_WIDTH+1)'(NUM_REGIONS);
   localparam logic [1:0] ERR_OK      = 2'b00;
   localparam logic [1:0] ERR_NOMATCH = 2'b01;
   localparam logic [1:0] ERR_PERM    = 2'b10;
   localparam logic [1:0] OP_READ     = 2'b00;
   localparam logic [1:0] OP_WRITE    = 2'b01;
   localparam logic [1:0] OP_FETCH    = 2'b10;
   localparam logic [1:0] FLD_BASE    = 2'b00;
   localparam logic [1:0] FLD_SIZE    = 2'b01;
   localparam logic [1:0] FLD_ATTR    = 2'b10;
   localparam logic [1:0] FLD_LOCK    = 2'b11;

   logic [AW-1:0]        base_q [NUM_REGIONS];
   logic [AW-1:0]        size_q [NUM_REGIONS];
   logic [2:0]           attr_q [NUM_REGIONS];
   logic                 locked_q;

   logic                 hit;
   logic [SEL_WIDTH-1:0] hit_sel;
   logic [AW-1:0]        hit_off;
   logic [2:0]           hit_attr;
   logic [AW-1:0]        off;
   logic                 perm_ok;
   logic [SEL_WIDTH-1:0] sel_d;
   logic [AW-1:0]        addr_d;
   logic [1:0]           err_d;

   logic                 rsp_valid_q;
   logic [SEL_WIDTH-1:0] rsp_sel_q;
   logic [AW-1:0]        rsp_addr_q;
   logic [1:0]           rsp_err_q;
   logic                 ready;
   logic                 cfg_ok;

   // Lowest matching index wins; subtract-then-compare avoids base+size overflow at the top of memory.
   always_comb begin
      hit      = 1'b0;
      hit_sel  = '0;
      hit_off  = '0;
      hit_attr = '0;
      off      = '0;
      for (int i = 0; i < NUM_REGIONS; i++) begin
         off = bus.req_addr - base_q[i];
         if (!hit && (size_q[i] != '0) && (bus.req_addr >= base_q[i]) && (off < size_q[i])) begin
            hit      = 1'b1;
            hit_sel  = SEL_WIDTH'(i);
            hit_off  = off;
            hit_attr = attr_q[i];
         end
      end
   end

   always_comb begin
      perm_ok = 1'b0;
      case (bus.req_op)
         OP_READ:  perm_ok = hit_attr[0];
         OP_WRITE: perm_ok = hit_attr[1];
         OP_FETCH: perm_ok = hit_attr[2];
         default:  perm_ok = 1'b0;
      endcase
   end

   always_comb begin
      sel_d  = '0;
      addr_d = bus.req_addr;
      err_d  = ERR_NOMATCH;
      if (hit && perm_ok) begin
         sel_d  = hit_sel;
         addr_d = hit_off;
         err_d  = ERR_OK;
      end else if (hit) begin
         err_d  = ERR_PERM;
      end
   end

   assign ready  = !rsp_valid_q || bus.rsp_ready;
   assign cfg_ok = bus.cfg_we && !locked_q && ({1'b0, bus.cfg_idx} < NUM_IDX);

   // Output register: holds the result stable under back-pressure.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid_q <= 1'b0;
         rsp_sel_q   <= '0;
         rsp_addr_q  <= '0;
         rsp_err_q   <= '0;
      end else if (ready) begin
         rsp_valid_q <= bus.req_valid;
         if (bus.req_valid) begin
            rsp_sel_q  <= sel_d;
            rsp_addr_q <= addr_d;
            rsp_err_q  <= err_d;
         end
      end
   end

   // Region table and sticky lock; same-cycle requests decode against the pre-write contents.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGIONS; i++) begin
            base_q[i] <= BASE_INIT[i*AW +: AW];
            size_q[i] <= SIZE_INIT[i*AW +: AW];
            attr_q[i] <= ATTR_INIT[i*3 +: 3];
         end
         locked_q <= 1'b0;
      end else if (cfg_ok) begin
         for (int i = 0; i < NUM_REGIONS; i++) begin
            if (bus.cfg_idx == SEL_WIDTH'(i)) begin
               case (bus.cfg_field)
                  FLD_BASE: base_q[i] <= bus.cfg_wdata;
                  FLD_SIZE: size_q[i] <= bus.cfg_wdata;
                  FLD_ATTR: attr_q[i] <= bus.cfg_wdata[2:0];
                  default:  ;
               endcase
            end
         end
         if ((bus.cfg_field == FLD_LOCK) && bus.cfg_wdata[0]) begin
            locked_q <= 1'b1;
         end
      end
   end

   assign bus.req_ready  = ready;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_sel    = rsp_sel_q;
   assign bus.rsp_addr   = rsp_addr_q;
   assign bus.rsp_err    = rsp_err_q;
   assign bus.cfg_locked = locked_q;
endmodule

// File: tb/tb_pma_decoder.sv
// Directed scoreboard bench for pma_decoder using the default region table.
module tb_pma_decoder;
   localparam int unsigned AW = 64;
   localparam int unsigned SW = 6;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pma_decoder_if #(.ADDR_WIDTH(AW), .SEL_WIDTH(SW)) bus ();
   pma_decoder dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic [SW-1:0] sel;
      logic [AW-1:0] addr;
      logic [1:0]    err;
      string         tag;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Response monitor: compares every accepted result against the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && bus.rsp_valid && bus.rsp_ready) begin
         check("rsp_expected", AW'(sb.size() != 0), AW'(1));
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check({e.tag, ".sel"},  AW'(bus.rsp_sel), AW'(e.sel));
            check({e.tag, ".addr"}, bus.rsp_addr,     e.addr);
            check({e.tag, ".err"},  AW'(bus.rsp_err), AW'(e.err));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [AW-1:0] a, input logic [1:0] op, input logic [SW-1:0] s,
                       input logic [AW-1:0] ea, input logic [1:0] ee, input string tag);
      int n;
      n = 0;
      bus.req_valid = 1'b1;
      bus.req_addr  = a;
      bus.req_op    = op;
      @(negedge clk);
      while (!bus.req_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!bus.req_ready) check({tag, ".accept_timeout"}, AW'(bus.req_ready), AW'(1));
      else sb.push_back('{s, ea, ee, tag});
      step();
      bus.req_valid = 1'b0;
   endtask

   task automatic cfg_write(input logic [SW-1:0] idx, input logic [1:0] fld, input logic [AW-1:0] d);
      bus.cfg_we    = 1'b1;
      bus.cfg_idx   = idx;
      bus.cfg_field = fld;
      bus.cfg_wdata = d;
      step();
      bus.cfg_we    = 1'b0;
   endtask

   initial begin
      rst           = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_addr  = '0;
      bus.req_op    = 2'b00;
      bus.rsp_ready = 1'b1;
      bus.cfg_we    = 1'b0;
      bus.cfg_idx   = '0;
      bus.cfg_field = 2'b00;
      bus.cfg_wdata = '0;

      repeat (2) @(negedge clk);
      check("rst.rsp_valid", AW'(bus.rsp_valid), AW'(0));
      check("rst.rsp_sel",   AW'(bus.rsp_sel),   AW'(0));
      check("rst.rsp_addr",  bus.rsp_addr,       AW'(0));
      check("rst.rsp_err",   AW'(bus.rsp_err),   AW'(0));
      check("rst.locked",    AW'(bus.cfg_locked), AW'(0));
      step();
      rst = 1'b0;

      // Default table decode, faults and region boundaries
      send(64'h8000_1234, 2'b00, 6'd4, 64'h1234,      2'b00, "ram_rd");
      send(64'h1000_0010, 2'b00, 6'd2, 64'h10,        2'b00, "uart_rd");
      send(64'h1000_0000, 2'b10, 6'd0, 64'h1000_0000, 2'b10, "uart_fetch");
      send(64'h2000_0000, 2'b00, 6'd0, 64'h2000_0000, 2'b01, "hole_rd");
      send(64'h1000_00FF, 2'b00, 6'd2, 64'hFF,        2'b00, "uart_last");
      send(64'h1000_0100, 2'b00, 6'd0, 64'h1000_0100, 2'b01, "uart_past");
      send(64'hFFFF_FFFF, 2'b00, 6'd4, 64'h7FFF_FFFF, 2'b00, "ram_top");
      send(64'h0000_0000, 2'b00, 6'd0, 64'h0,         2'b10, "zero_page");
      send(64'h8000_0000, 2'b11, 6'd0, 64'h8000_0000, 2'b10, "op_rsvd");
      send(64'h0000_2000, 2'b01, 6'd0, 64'h2000,      2'b10, "rom_wr");
      send(64'h0FFF_FFFC, 2'b10, 6'd1, 64'h0FFF_EFFC, 2'b00, "rom_fetch");
      step();
      step();

      // Back-pressure: one result held, second request waiting
      bus.rsp_ready = 1'b0;
      send(64'h8000_0010, 2'b00, 6'd4, 64'h10, 2'b00, "bp_first");
      bus.req_valid = 1'b1;
      bus.req_addr  = 64'h1000_1004;
      bus.req_op    = 2'b00;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("bp.req_ready", AW'(bus.req_ready), AW'(0));
         check("bp.rsp_valid", AW'(bus.rsp_valid), AW'(1));
         check("bp.hold_sel",  AW'(bus.rsp_sel),   AW'(4));
         check("bp.hold_addr", bus.rsp_addr,       AW'(64'h10));
         check("bp.hold_err",  AW'(bus.rsp_err),   AW'(0));
      end
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      check("bp.release_ready", AW'(bus.req_ready), AW'(1));
      sb.push_back('{6'd3, 64'h4, 2'b00, "bp_second"});
      step();
      bus.req_valid = 1'b0;
      step();

      // Reprogram entry 5; size written in the same cycle as the request
      cfg_write(6'd5, 2'b00, 64'h4000_0000);
      cfg_write(6'd5, 2'b10, 64'h3);
      bus.cfg_we    = 1'b1;
      bus.cfg_idx   = 6'd5;
      bus.cfg_field = 2'b01;
      bus.cfg_wdata = 64'h1000;
      send(64'h4000_0010, 2'b00, 6'd0, 64'h4000_0010, 2'b01, "same_cycle");
      bus.cfg_we = 1'b0;
      send(64'h4000_0010, 2'b00, 6'd5, 64'h10, 2'b00, "new_entry");

      // Overlap: entry 2 now covers the start of RAM and wins over entry 4
      cfg_write(6'd2, 2'b00, 64'h8000_0000);
      cfg_write(6'd2, 2'b01, 64'h1000);
      send(64'h8000_0020, 2'b00, 6'd2, 64'h20,   2'b00, "overlap_lo");
      send(64'h8000_2000, 2'b00, 6'd4, 64'h2000, 2'b00, "overlap_hi");

      // Lock via an out-of-range index has no effect
      cfg_write(6'd8, 2'b11, 64'h1);
      check("badidx.locked", AW'(bus.cfg_locked), AW'(0));

      // Lock, then attempted writes and unlock are ignored
      cfg_write(6'd0, 2'b11, 64'h1);
      check("lock.set", AW'(bus.cfg_locked), AW'(1));
      cfg_write(6'd1, 2'b01, 64'h0);
      send(64'h0000_1000, 2'b10, 6'd1, 64'h0, 2'b00, "locked_rom");
      cfg_write(6'd0, 2'b11, 64'h0);
      check("lock.sticky", AW'(bus.cfg_locked), AW'(1));
      step();

      // Reset mid-stall drops the held result and restores the table
      bus.rsp_ready = 1'b0;
      send(64'h8000_0000, 2'b00, 6'd2, 64'h0, 2'b00, "dropped");
      check("stall.rsp_valid", AW'(bus.rsp_valid), AW'(1));
      #2;
      rst = 1'b1;
      #1;
      check("midrst.rsp_valid", AW'(bus.rsp_valid),  AW'(0));
      check("midrst.locked",    AW'(bus.cfg_locked), AW'(0));
      sb.delete();
      step();
      rst = 1'b0;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      check("postrst.rsp_valid", AW'(bus.rsp_valid), AW'(0));
      step();
      send(64'h8000_0020, 2'b00, 6'd4, 64'h20,        2'b00, "postrst_ram");
      send(64'h4000_0010, 2'b00, 6'd0, 64'h4000_0010, 2'b01, "postrst_e5");
      send(64'h0000_1000, 2'b10, 6'd1, 64'h0,         2'b00, "postrst_rom");

      repeat (3) step();
      check("sb.drained", AW'(sb.size()), AW'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
